// File: rtl/write_channels_mngr_pkg.sv
// Shared widths, constants and FSM encoding for the tiny_axi write manager.
package write_channels_mngr_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int LINE_W     = 128;
  localparam logic [5:0] ATOP_NONE = 6'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    WAIT_B = 2'd2
  } state_e;
endpackage

// File: rtl/write_channels_mngr_if.sv
// Local request/completion plus AW/W/B channels of the tiny_axi write path.
interface write_channels_mngr_if;
  import write_channels_mngr_pkg::*;

  logic                  wreq_m_valid;
  logic                  wreq_m_ready;
  logic [AXI_ADDR_W-1:0] wreq_m_addr;
  logic [LINE_W-1:0]     wreq_m_data;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_ID_W-1:0]   awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [5:0]            awatop;
  logic                  wvalid;
  logic                  wready;
  logic [AXI_DATA_W-1:0] wdata;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ID_W-1:0]   bid;
  logic                  bcomp;
  logic                  wcomp_m_valid;
  logic                  wcomp_m_err;

  modport master (
    input  wreq_m_valid, wreq_m_addr, wreq_m_data, awready, wready, bvalid, bid, bcomp,
    output wreq_m_ready, awvalid, awid, awaddr, awatop, wvalid, wdata, wlast, bready,
           wcomp_m_valid, wcomp_m_err
  );
  modport slave (
    output wreq_m_valid, wreq_m_addr, wreq_m_data, awready, wready, bvalid, bid, bcomp,
    input  wreq_m_ready, awvalid, awid, awaddr, awatop, wvalid, wdata, wlast, bready,
           wcomp_m_valid, wcomp_m_err
  );
endinterface

// File: rtl/write_channels_mngr_wdata.sv
// W channel: latches a 128-bit line on start and serializes it as BEATS
// 32-bit beats, beat 0 from the low word.
module wdata_chan_mngr
  import write_channels_mngr_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LINE_W-1:0]     line,
  input  logic                  wready,
  output logic                  wvalid,
  output logic [AXI_DATA_W-1:0] wdata,
  output logic                  wlast,
  output logic                  w_done
);
  logic [BEATS-1:0][AXI_DATA_W-1:0] beats_q;
  logic [1:0]                       beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0;
      beat    <= '0;
      wvalid  <= 1'b0;
      w_done  <= 1'b0;
    end else if (start) begin
      beats_q <= line;
      beat    <= '0;
      wvalid  <= 1'b1;
      w_done  <= 1'b0;
    end else if (wvalid && wready) begin
      // The beat counter parks on the last beat so wdata stays put after done.
      if (beat == 2'(BEATS-1)) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end else begin
        beat <= beat + 2'd1;
      end
    end
  end

  assign wdata = beats_q[beat];
  assign wlast = wvalid && (beat == 2'(BEATS-1));
endmodule

// File: rtl/write_channels_mngr.sv
// tiny_axi write manager: one local 128-bit write -> AW + 4 W beats -> B,
// then a one-cycle completion pulse. One transaction in flight.
module write_channels_mngr
  import write_channels_mngr_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] ID_INIT = 4'h0,
  parameter int                  BEATS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  write_channels_mngr_if.master bus
);
  state_e                state;
  logic [AXI_ID_W-1:0]   id_cnt;
  logic                  aw_done;
  logic                  accept, aw_fin, w_fin;
  logic                  wvalid, wlast, w_done;
  logic [AXI_DATA_W-1:0] wdata;

  assign accept = (state == IDLE) && bus.wreq_m_ready && bus.wreq_m_valid;
  // Both channels may finish on the same edge; look through this cycle's handshakes.
  assign aw_fin = aw_done || (bus.awvalid && bus.awready);
  assign w_fin  = w_done  || (wvalid && bus.wready && wlast);

  wdata_chan_mngr #(.BEATS(BEATS)) u_wdata (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .line   (bus.wreq_m_data),
    .wready (bus.wready),
    .wvalid (wvalid),
    .wdata  (wdata),
    .wlast  (wlast),
    .w_done (w_done)
  );

  assign bus.wvalid = wvalid;
  assign bus.wdata  = wdata;
  assign bus.wlast  = wlast;
  assign bus.awatop = ATOP_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      id_cnt            <= ID_INIT;
      aw_done           <= 1'b0;
      bus.wreq_m_ready  <= 1'b1;
      bus.awvalid       <= 1'b0;
      bus.awid          <= '0;
      bus.awaddr        <= '0;
      bus.bready        <= 1'b0;
      bus.wcomp_m_valid <= 1'b0;
      bus.wcomp_m_err   <= 1'b0;
    end else begin
      bus.wcomp_m_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.wreq_m_ready <= 1'b1;
          if (accept) begin
            bus.wreq_m_ready <= 1'b0;
            bus.awvalid      <= 1'b1;
            bus.awid         <= id_cnt;
            bus.awaddr       <= bus.wreq_m_addr;
            id_cnt           <= id_cnt + 4'd1;
            aw_done          <= 1'b0;
            state            <= XFER;
          end
        end
        XFER: begin
          if (bus.awvalid && bus.awready) begin
            bus.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bus.bready <= 1'b1;
            state      <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.bvalid) begin
            bus.bready        <= 1'b0;
            bus.wcomp_m_valid <= 1'b1;
            bus.wcomp_m_err   <= ~bus.bcomp | (bus.bid != bus.awid);
            // Ready comes back one cycle later, so it stays low through the pulse.
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_channels_mngr.sv
// Directed bench for write_channels_mngr: single write, backpressure,
// same-edge finish, error responses, id wrap and mid-transfer reset.
module tb_write_channels_mngr;
  import write_channels_mngr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  write_channels_mngr_if bus();
  write_channels_mngr #(.ID_INIT(4'h0), .BEATS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_run  = 0;
  int n_fail = 0;

  wire [79:0] outs = {bus.awvalid, bus.awid, bus.awaddr, bus.awatop, bus.wvalid, bus.wdata,
                      bus.wlast, bus.bready, bus.wcomp_m_valid, bus.wcomp_m_err};

  localparam logic [127:0] D0 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] D1 = 128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0;
  localparam logic [127:0] D2 = 128'hC0DE_0003_C0DE_0002_C0DE_0001_C0DE_0000;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wreq_m_valid = 1'b0; bus.wreq_m_addr = '0; bus.wreq_m_data = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bid = '0; bus.bcomp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (outs !== 80'h0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", outs); end
    n_run++;
    if (bus.wreq_m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.wreq_m_ready); end
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = D0;
    @(negedge clk);
    bus.awready = 1'b1; bus.wready = 1'b1;
    n_run++;
    if (bus.wreq_m_ready !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %b want 1", bus.wreq_m_ready); end
    bus.wreq_m_valid = 1'b1; bus.wreq_m_addr = 32'h0000_1000; bus.wreq_m_data = D0;
    @(negedge clk);
    bus.wreq_m_valid = 1'b0; bus.wreq_m_addr = 32'hDEAD_BEE0; bus.wreq_m_data = '1;
    n_run++;
    if ({bus.awvalid, bus.awid, bus.awaddr} !== {1'b1, 4'h0, 32'h0000_1000}) begin
      n_fail++; $display("FAIL single_aw: got %b/%h/%h want 1/0/00001000", bus.awvalid, bus.awid, bus.awaddr);
    end
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      n_run++;
      if ({bus.wvalid, bus.wdata, bus.wlast, bus.bready, bus.wreq_m_ready} !== {1'b1, d[32*b +: 32], b == 3, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL single_beat%0d: got v%b d%h l%b br%b rdy%b want v1 d%h l%b br0 rdy0",
                           b, bus.wvalid, bus.wdata, bus.wlast, bus.bready, bus.wreq_m_ready, d[32*b +: 32], b == 3);
      end
      if (b == 1) begin
        n_run++;
        if (bus.awvalid !== 1'b0) begin n_fail++; $display("FAIL single_aw_drop: got %b want 0", bus.awvalid); end
      end
    end
    @(negedge clk);
    n_run++;
    if ({bus.bready, bus.wvalid} !== 2'b10) begin n_fail++; $display("FAIL single_waitb: got br%b wv%b want br1 wv0", bus.bready, bus.wvalid); end
    bus.bvalid = 1'b1; bus.bid = 4'h0; bus.bcomp = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b0;
    n_run++;
    if ({bus.wcomp_m_valid, bus.wcomp_m_err, bus.bready, bus.wreq_m_ready} !== 4'b1000) begin
      n_fail++; $display("FAIL single_comp: got v%b e%b br%b rdy%b want v1 e0 br0 rdy0",
                         bus.wcomp_m_valid, bus.wcomp_m_err, bus.bready, bus.wreq_m_ready);
    end
    @(negedge clk);
    n_run++;
    if ({bus.wcomp_m_valid, bus.wreq_m_ready} !== 2'b01) begin
      n_fail++; $display("FAIL single_after: got v%b rdy%b want v0 rdy1", bus.wcomp_m_valid, bus.wreq_m_ready);
    end
  endtask

  // awready low 5 cycles, wready on odd cycles, stray bvalid early in XFER.
  task automatic test_backpressure();
    logic [127:0] d;
    int  beat;
    bit  awd, wd, entered;
    d = D1; beat = 0; awd = 0; wd = 0; entered = 0;
    @(negedge clk);
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.wreq_m_valid = 1'b1; bus.wreq_m_addr = 32'h0000_2340; bus.wreq_m_data = D1;
    @(negedge clk);
    bus.wreq_m_valid = 1'b0;
    for (int c = 0; c < 40 && !entered; c++) begin
      n_run++;
      if (bus.awvalid !== !awd || (!awd && {bus.awid, bus.awaddr} !== {4'h1, 32'h0000_2340})) begin
        n_fail++; $display("FAIL bp_aw c%0d: got v%b id%h a%h want v%b id1 a00002340", c, bus.awvalid, bus.awid, bus.awaddr, !awd);
      end
      n_run++;
      if (bus.wvalid !== !wd || (!wd && {bus.wdata, bus.wlast} !== {d[32*beat +: 32], beat == 3})) begin
        n_fail++; $display("FAIL bp_w c%0d: got v%b d%h l%b want v%b d%h l%b", c, bus.wvalid, bus.wdata, bus.wlast,
                           !wd, d[32*beat +: 32], beat == 3);
      end
      n_run++;
      if (bus.bready !== 1'b0) begin n_fail++; $display("FAIL bp_bready c%0d: got %b want 0", c, bus.bready); end
      bus.awready = (c >= 5);
      bus.wready  = c[0];
      bus.bvalid  = (c < 3); bus.bid = 4'h1; bus.bcomp = 1'b1;
      if (bus.awready && !awd) awd = 1;
      if (bus.wready && !wd) begin
        if (beat == 3) wd = 1; else beat++;
      end
      @(negedge clk);
      if (awd && wd) entered = 1;
    end
    n_run++;
    if (!entered || bus.bready !== 1'b1) begin n_fail++; $display("FAIL bp_waitb: got entered%b br%b want 1 1", entered, bus.bready); end
    bus.bvalid = 1'b1; bus.bid = 4'h1; bus.bcomp = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b0;
    n_run++;
    if ({bus.wcomp_m_valid, bus.wcomp_m_err} !== 2'b10) begin
      n_fail++; $display("FAIL bp_comp: got v%b e%b want v1 e0", bus.wcomp_m_valid, bus.wcomp_m_err);
    end
    @(negedge clk);
  endtask

  // AW accepted on the beat-3 edge; completion carries a wrong bid.
  task automatic test_same_cycle();
    logic [127:0] d;
    d = D2;
    bus.awready = 1'b0; bus.wready = 1'b1;
    bus.wreq_m_valid = 1'b1; bus.wreq_m_addr = 32'h0000_3000; bus.wreq_m_data = D2;
    @(negedge clk);
    bus.wreq_m_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      n_run++;
      if ({bus.awvalid, bus.awid, bus.wvalid, bus.wdata, bus.wlast} !== {1'b1, 4'h2, 1'b1, d[32*b +: 32], b == 3}) begin
        n_fail++; $display("FAIL same_beat%0d: got av%b id%h wv%b d%h l%b want av1 id2 wv1 d%h l%b",
                           b, bus.awvalid, bus.awid, bus.wvalid, bus.wdata, bus.wlast, d[32*b +: 32], b == 3);
      end
      if (b == 3) bus.awready = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.awready = 1'b0;
      n_run++;
      if ({bus.bready, bus.awvalid, bus.wvalid, bus.wlast} !== 4'b1000) begin
        n_fail++; $display("FAIL same_waitb%0d: got br%b av%b wv%b l%b want br1 av0 wv0 l0",
                           k, bus.bready, bus.awvalid, bus.wvalid, bus.wlast);
      end
    end
    bus.bvalid = 1'b1; bus.bid = 4'h5; bus.bcomp = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b0;
    n_run++;
    if ({bus.wcomp_m_valid, bus.wcomp_m_err} !== 2'b11) begin
      n_fail++; $display("FAIL bid_err: got v%b e%b want v1 e1", bus.wcomp_m_valid, bus.wcomp_m_err);
    end
    @(negedge clk);
  endtask

  task automatic test_bcomp_err();
    bus.awready = 1'b1; bus.wready = 1'b1;
    bus.wreq_m_valid = 1'b1; bus.wreq_m_addr = 32'h0000_5550; bus.wreq_m_data = D0;
    @(negedge clk);
    bus.wreq_m_valid = 1'b0;
    n_run++;
    if (bus.awid !== 4'h3) begin n_fail++; $display("FAIL bcomp_awid: got %h want 3", bus.awid); end
    repeat (4) @(negedge clk);
    n_run++;
    if (bus.bready !== 1'b1) begin n_fail++; $display("FAIL bcomp_bready: got %b want 1", bus.bready); end
    bus.bvalid = 1'b1; bus.bid = 4'h3; bus.bcomp = 1'b0;
    @(negedge clk);
    bus.bvalid = 1'b0;
    n_run++;
    if ({bus.wcomp_m_valid, bus.wcomp_m_err} !== 2'b11) begin
      n_fail++; $display("FAIL bcomp_err: got v%b e%b want v1 e1", bus.wcomp_m_valid, bus.wcomp_m_err);
    end
    @(negedge clk);
  endtask

  task automatic test_id_wrap();
    do_reset();
    bus.awready = 1'b1; bus.wready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      n_run++;
      if (bus.wreq_m_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_rdy i%0d: got %b want 1", i, bus.wreq_m_ready); end
      bus.wreq_m_valid = 1'b1; bus.wreq_m_addr = 32'(i * 16); bus.wreq_m_data = D2;
      @(negedge clk);
      bus.wreq_m_valid = 1'b0;
      n_run++;
      if (bus.awid !== 4'(i)) begin n_fail++; $display("FAIL wrap_awid i%0d: got %h want %h", i, bus.awid, 4'(i)); end
      for (int k = 0; k < 4; k++) begin
        n_run++;
        if (bus.wreq_m_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_busy i%0d k%0d: got %b want 0", i, k, bus.wreq_m_ready); end
        @(negedge clk);
      end
      n_run++;
      if ({bus.bready, bus.wreq_m_ready} !== 2'b10) begin
        n_fail++; $display("FAIL wrap_waitb i%0d: got br%b rdy%b want br1 rdy0", i, bus.bready, bus.wreq_m_ready);
      end
      bus.bvalid = 1'b1; bus.bid = 4'(i); bus.bcomp = 1'b1;
      @(negedge clk);
      bus.bvalid = 1'b0;
      n_run++;
      if ({bus.wcomp_m_valid, bus.wcomp_m_err, bus.wreq_m_ready} !== 3'b100) begin
        n_fail++; $display("FAIL wrap_comp i%0d: got v%b e%b rdy%b want v1 e0 rdy0",
                           i, bus.wcomp_m_valid, bus.wcomp_m_err, bus.wreq_m_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    d = D0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    bus.wreq_m_valid = 1'b1; bus.wreq_m_addr = 32'h0000_4000; bus.wreq_m_data = D0;
    @(negedge clk);
    bus.wreq_m_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_run++;
    if ({bus.wvalid, bus.wdata} !== {1'b1, d[95:64]}) begin
      n_fail++; $display("FAIL rmid_beat2: got v%b d%h want v1 d%h", bus.wvalid, bus.wdata, d[95:64]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_run++;
    if (outs !== 80'h0 || bus.wreq_m_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_outs: got %h rdy%b want 0 rdy1", outs, bus.wreq_m_ready);
    end
    bus.bvalid = 1'b1; bus.bid = 4'h1; bus.bcomp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_run++;
      if ({bus.wcomp_m_valid, bus.bready} !== 2'b00) begin
        n_fail++; $display("FAIL rmid_nocomp k%0d: got v%b br%b want 0 0", k, bus.wcomp_m_valid, bus.bready);
      end
    end
    bus.bvalid = 1'b0;
    bus.wreq_m_valid = 1'b1; bus.wreq_m_addr = 32'h0000_6000; bus.wreq_m_data = D1;
    @(negedge clk);
    bus.wreq_m_valid = 1'b0;
    n_run++;
    if ({bus.awvalid, bus.awid, bus.awaddr} !== {1'b1, 4'h0, 32'h0000_6000}) begin
      n_fail++; $display("FAIL rmid_next: got v%b id%h a%h want v1 id0 a00006000", bus.awvalid, bus.awid, bus.awaddr);
    end
    repeat (4) @(negedge clk);
    bus.bvalid = 1'b1; bus.bid = 4'h0; bus.bcomp = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b0;
    n_run++;
    if ({bus.wcomp_m_valid, bus.wcomp_m_err} !== 2'b10) begin
      n_fail++; $display("FAIL rmid_comp: got v%b e%b want v1 e0", bus.wcomp_m_valid, bus.wcomp_m_err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_same_cycle();
    test_bcomp_err();
    test_id_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d run %0d failed", n_run, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
